peak_serializer: RTL and testbench
==================================

PEAK_SERIALIZER -- requirements
Module: peak_serializer

Interface
REQ-001 SHALL have parameter N_PEAKS, default 16, number of spectral peaks per frame.
REQ-002 SHALL have parameter ENTRY_W, default 25, width of one peak entry: frequency bin in [ENTRY_W-1:MAG_W], magnitude in [MAG_W-1:0].
REQ-003 SHALL have parameter FREQ_W, default 9, frequency-bin width; MAG_W, default 16, magnitude width; ENTRY_W = FREQ_W + MAG_W.
REQ-004 SHALL have parameter MARKER, default 9'h1FF, end-of-frame code; EMIT_MARKER, default 1, enables it.
REQ-005 SHALL have port clk, input, 1, single clock for all logic.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port load, input, 1, single-cycle pulse: peak array valid.
REQ-008 SHALL have port data_in, input, N_PEAKS x ENTRY_W unpacked array, peak entries with index 0 first.
REQ-009 SHALL have port mag_threshold, input, MAG_W, minimum magnitude for emission.
REQ-010 SHALL have port out_ready, input, 1, downstream can accept (FIFO not full).
REQ-011 SHALL have port out_data, output, FREQ_W, emitted frequency bin or MARKER.
REQ-012 SHALL have port out_valid, output, 1, out_data valid.
REQ-013 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-014 SHALL have port frame_dropped, output, 1, one-cycle pulse when load is ignored.

Function
REQ-015 SHALL implement states IDLE, SCAN, HOLD, MARK.
REQ-016 SHALL, in IDLE, when load=1, capture all data_in entries and mag_threshold into registers, set idx=0, and go to SCAN.
REQ-017 SHALL, in SCAN, go to HOLD with out_data=freq[idx] and out_valid=1 if mag[idx] >= captured threshold (unsigned compare); otherwise skip the entry.
REQ-018 SHALL, on a skip or HOLD handshake at idx=N_PEAKS-1, go to MARK if EMIT_MARKER=1, else IDLE; otherwise idx increments and the state returns to SCAN.
REQ-019 SHALL hold out_data and out_valid stable in HOLD until out_valid & out_ready; handshake cycle clears out_valid next cycle.
REQ-020 SHALL, in MARK, present out_data=MARKER, out_valid=1 until handshake, then go to IDLE.
REQ-021 SHALL drive out_data and out_valid from registers only; no combinational path from load or out_ready.
REQ-022 SHALL emit the first qualifying entry with out_valid rising two cycles after load (load at t, SCAN at t+1, valid at t+2).
REQ-023 SHALL spend exactly one cycle per skipped entry; a frame with no qualifying entries emits only MARKER, valid at t+1+N_PEAKS.
REQ-024 SHALL ignore load while busy=1 (captured entries unchanged) and pulse frame_dropped for that cycle.
REQ-025 SHALL ignore load in the cycle MARK/HOLD returns to IDLE (state still non-IDLE then); accepted only when state==IDLE.
REQ-026 SHALL keep idx width clog2(N_PEAKS) with no wrap beyond N_PEAKS-1.
REQ-027 SHALL tolerate out_ready held low indefinitely, with no data loss or state change.

Reset
REQ-028 SHALL, on rst_n=0, immediately go to IDLE, clear idx, out_data=0, out_valid=0, frame_dropped=0, busy=0.
REQ-029 SHALL abandon any in-progress frame on reset mid-operation; no partial marker emitted afterwards.
REQ-030 SHALL not require the captured entry array to be reset.

Structure
REQ-031 SHALL take N_PEAKS, FREQ_W, MAG_W, MARKER defaults and the state enum from shared package shazam_pkg.
REQ-032 SHALL be a single module; no sub-module required.

Verification
REQ-033 SHALL cover: threshold=0, entries freq=i+1 for i=0..15, out_ready=1 -> out_data 1..16 then 9'h1FF, 17 handshakes, first valid at t+2.
REQ-034 SHALL cover: threshold=100, only entries 3 and 10 with mag>=100 -> outputs freq[3], freq[10], 9'h1FF only.
REQ-035 SHALL cover: all mags below threshold -> single 9'h1FF valid at load+17 cycles.
REQ-036 SHALL cover: out_ready=0 for 50 cycles during HOLD of entry 0 -> out_data stable, out_valid=1, then sequence resumes intact.
REQ-037 SHALL cover: second load pulse during SCAN -> frame_dropped pulses once, first frame output unchanged.
REQ-038 SHALL cover: rst_n low in HOLD at idx=5 -> out_valid=0 asynchronously, busy=0, next load restarts at entry 0.

Source files
------------

// File: rtl/shazam_pkg.sv
// Shared defaults and state encoding for the peak serializer.
package shazam_pkg;

   localparam int unsigned N_PEAKS_DEF = 16;
   localparam int unsigned FREQ_W_DEF  = 9;
   localparam int unsigned MAG_W_DEF   = 16;
   localparam logic [8:0]  MARKER_DEF  = 9'h1FF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      HOLD = 2'd2,
      MARK = 2'd3
   } ser_state_t;

endpackage : shazam_pkg

// File: rtl/peak_serializer.sv
// Walks a captured spectral-peak array and emits the frequency bin of every
// entry whose magnitude meets the threshold, then an optional end-of-frame
// marker, over a valid/ready stream.
module peak_serializer
   import shazam_pkg::*;
#(
   parameter int unsigned       N_PEAKS     = N_PEAKS_DEF,
   parameter int unsigned       FREQ_W      = FREQ_W_DEF,
   parameter int unsigned       MAG_W       = MAG_W_DEF,
   parameter int unsigned       ENTRY_W     = FREQ_W + MAG_W,
   parameter logic [FREQ_W-1:0] MARKER      = FREQ_W'(MARKER_DEF),
   parameter bit                EMIT_MARKER = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic [ENTRY_W-1:0] data_in [N_PEAKS],
   input  logic [MAG_W-1:0]   mag_threshold,
   input  logic               out_ready,
   output logic [FREQ_W-1:0]  out_data,
   output logic               out_valid,
   output logic               busy,
   output logic               frame_dropped
);

   localparam int unsigned     IDX_W    = (N_PEAKS > 1) ? $clog2(N_PEAKS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PEAKS - 1);

   ser_state_t          r_state;
   ser_state_t          w_state_nxt;
   logic [IDX_W-1:0]    r_idx;
   logic [IDX_W-1:0]    w_idx_nxt;
   logic [FREQ_W-1:0]   r_out_data;
   logic [FREQ_W-1:0]   w_data_nxt;
   logic                r_out_valid;
   logic                w_valid_nxt;
   logic                r_busy;
   logic                r_dropped;
   logic                w_dropped_nxt;
   logic                w_capture;
   logic                w_advance;
   logic [ENTRY_W-1:0]  r_entries [N_PEAKS];
   logic [MAG_W-1:0]    r_thr;
   logic [ENTRY_W-1:0]  w_entry;
   logic [FREQ_W-1:0]   w_freq;
   logic [MAG_W-1:0]    w_mag;
   logic                w_last;

   assign w_entry = r_entries[r_idx];
   assign w_freq  = w_entry[ENTRY_W-1:MAG_W];
   assign w_mag   = w_entry[MAG_W-1:0];
   assign w_last  = (r_idx == LAST_IDX);

   // Frame capture; contents are only meaningful once a load was accepted.
   always_ff @(posedge clk) begin
      if (w_capture) begin
         r_entries <= data_in;
         r_thr     <= mag_threshold;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_idx       <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_dropped   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_idx       <= w_idx_nxt;
         r_out_data  <= w_data_nxt;
         r_out_valid <= w_valid_nxt;
         r_busy      <= (w_state_nxt != IDLE);
         r_dropped   <= w_dropped_nxt;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      w_state_nxt   = r_state;
      w_idx_nxt     = r_idx;
      w_data_nxt    = r_out_data;
      w_valid_nxt   = r_out_valid;
      w_dropped_nxt = load && (r_state != IDLE);
      w_capture     = 1'b0;
      w_advance     = 1'b0;

      case (r_state)
         IDLE: begin
            if (load) begin
               w_capture   = 1'b1;
               w_idx_nxt   = '0;
               w_state_nxt = SCAN;
            end
         end
         SCAN: begin
            if (w_mag >= r_thr) begin
               w_data_nxt  = w_freq;
               w_valid_nxt = 1'b1;
               w_state_nxt = HOLD;
            end else begin
               w_advance = 1'b1;
            end
         end
         HOLD: begin
            if (r_out_valid && out_ready) begin
               w_valid_nxt = 1'b0;
               w_advance   = 1'b1;
            end
         end
         MARK: begin
            if (r_out_valid && out_ready) begin
               w_valid_nxt = 1'b0;
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_valid_nxt = 1'b0;
            w_state_nxt = IDLE;
         end
      endcase

      // Move past the current entry: next entry, marker, or done.
      if (w_advance) begin
         if (!w_last) begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_state_nxt = SCAN;
         end else if (EMIT_MARKER) begin
            w_data_nxt  = MARKER;
            w_valid_nxt = 1'b1;
            w_state_nxt = MARK;
         end else begin
            w_state_nxt = IDLE;
         end
      end
   end

   assign out_data      = r_out_data;
   assign out_valid     = r_out_valid;
   assign busy          = r_busy;
   assign frame_dropped = r_dropped;

endmodule : peak_serializer

// File: tb/tb_peak_serializer.sv
// Scoreboard bench for peak_serializer: frames are modelled as the list of
// qualifying bins plus the marker; a monitor pops and compares on handshakes.
module tb_peak_serializer;

   localparam int unsigned N  = 16;
   localparam int unsigned FW = 9;
   localparam int unsigned MW = 16;
   localparam int unsigned EW = FW + MW;
   localparam logic [FW-1:0] MARK_CODE = 9'h1FF;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          load;
   logic [EW-1:0] data_in [N];
   logic [MW-1:0] mag_threshold;
   logic          out_ready;
   logic [FW-1:0] out_data;
   logic          out_valid;
   logic          busy;
   logic          frame_dropped;

   peak_serializer dut (
      .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in),
      .mag_threshold(mag_threshold), .out_ready(out_ready),
      .out_data(out_data), .out_valid(out_valid), .busy(busy),
      .frame_dropped(frame_dropped)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int n_pops   = 0;
   int drop_cnt = 0;
   logic [FW-1:0] exp_q [$];
   logic [FW-1:0] fr_freq [N];
   logic [MW-1:0] fr_mag  [N];
   bit rand_ready  = 1'b0;
   bit force_ready = 1'b1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every accepted output must match the oldest expected bin.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_output: got %0h expected nothing at %0t", out_data, $time);
         end else begin
            check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
            n_pops++;
         end
      end
      if (frame_dropped) drop_cnt++;
   end

   // Downstream ready: forced level or random back-pressure.
   always @(posedge clk) begin
      #1;
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : force_ready;
   end

   // Fill the frame buffer: freq random or i+1, magnitudes relative to thr.
   task automatic gen_frame(input bit seq_freq, input logic [MW-1:0] lo, input logic [MW-1:0] hi);
      for (int i = 0; i < N; i++) begin
         fr_freq[i] = seq_freq ? FW'(i + 1) : FW'($urandom_range(0, 510));
         fr_mag[i]  = MW'($urandom_range(32'(lo), 32'(hi)));
      end
   endtask

   // Drive one load pulse and record the frame's expected output stream.
   task automatic send_frame(input logic [MW-1:0] thr);
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) data_in[i] = {fr_freq[i], fr_mag[i]};
      mag_threshold = thr;
      load = 1'b1;
      for (int i = 0; i < N; i++)
         if (fr_mag[i] >= thr) exp_q.push_back(fr_freq[i]);
      exp_q.push_back(MARK_CODE);
      @(posedge clk); #1;
      load = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while ((busy || exp_q.size() != 0) && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      check(name, 32'(n < 3000), 32'd1);
   endtask

   initial begin
      int lat;
      int p0;
      int d0;
      logic [FW-1:0] held;
      rst_n = 1'b0;
      load = 1'b0;
      mag_threshold = '0;
      for (int i = 0; i < N; i++) data_in[i] = '0;
      #17;
      check("reset_valid", 32'(out_valid), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_data", 32'(out_data), 32'd0);
      check("reset_drop", 32'(frame_dropped), 32'd0);
      #6 rst_n = 1'b1;

      // Threshold 0, sequential bins: all 16 plus marker, first valid at t+2.
      gen_frame(1'b1, 0, 16'hFFFF);
      p0 = n_pops;
      send_frame(16'd0);
      check("scan_not_valid_t1", 32'(out_valid), 32'd0);
      wait_valid(lat);
      check("first_valid_latency", 32'(lat), 32'd1);
      wait_done("frame1_done");
      check("frame1_handshakes", 32'(n_pops - p0), 32'd17);

      // Threshold 100: only entries 3 and 10 qualify.
      gen_frame(1'b0, 0, 99);
      fr_mag[3]  = 16'd100;
      fr_mag[10] = MW'($urandom_range(100, 65535));
      p0 = n_pops;
      send_frame(16'd100);
      wait_done("frame2_done");
      check("frame2_handshakes", 32'(n_pops - p0), 32'd3);

      // Nothing qualifies: lone marker at t+1+N.
      gen_frame(1'b0, 0, 499);
      send_frame(16'd500);
      wait_valid(lat);
      check("marker_only_latency", 32'(lat), 32'd16);
      check("marker_only_data", 32'(out_data), 32'(MARK_CODE));
      wait_done("frame3_done");

      // Back-pressure held for 50 cycles on entry 0.
      force_ready = 1'b0;
      gen_frame(1'b1, 0, 16'hFFFF);
      send_frame(16'd0);
      wait_valid(lat);
      held = out_data;
      check("stall_first_bin", 32'(held), 32'd1);
      repeat (50) begin
         @(posedge clk); #1;
         check("stall_valid", 32'(out_valid), 32'd1);
         check("stall_data", 32'(out_data), 32'(held));
      end
      force_ready = 1'b1;
      wait_done("frame4_done");

      // Second load during SCAN is dropped and does not disturb the frame.
      d0 = drop_cnt;
      gen_frame(1'b0, 0, 16'hFFFF);
      send_frame(16'h4000);
      for (int i = 0; i < N; i++) data_in[i] = EW'($urandom);
      mag_threshold = 16'd0;
      load = 1'b1;
      @(posedge clk); #1;
      load = 1'b0;
      wait_done("frame5_done");
      check("drop_pulses", 32'(drop_cnt - d0), 32'd1);

      // Reset while holding entry 5; next frame restarts cleanly.
      gen_frame(1'b1, 0, 16'hFFFF);
      send_frame(16'd0);
      lat = 0;
      while (!(out_valid && out_data == FW'(6)) && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      check("reach_entry5", 32'(lat < 200), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_valid", 32'(out_valid), 32'd0);
      check("async_rst_busy", 32'(busy), 32'd0);
      exp_q.delete();
      @(posedge clk); #4 rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("post_rst_idle", 32'(busy), 32'd0);
      gen_frame(1'b1, 0, 16'hFFFF);
      p0 = n_pops;
      send_frame(16'd0);
      wait_done("frame6_done");
      check("post_rst_handshakes", 32'(n_pops - p0), 32'd17);

      // Random frames under random back-pressure.
      rand_ready = 1'b1;
      for (int f = 0; f < 8; f++) begin
         gen_frame(1'b0, 0, 16'hFFFF);
         send_frame(MW'($urandom));
         wait_done("rand_frame_done");
      end
      rand_ready = 1'b0;
      repeat (5) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_peak_serializer
